// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: IF stage. Generates the fetch PC, keeps one i-cache request in flight,
// buffers returned {pc,inst} words in a prefetch FIFO and flushes IF/ID on redirect.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advanceIn,
    input  logic        redirectIn,
    input  logic [31:0] redirectPcIn,
    output logic        memReqOut,
    output logic [31:0] memAddrOut,
    input  logic        memAckIn,
    input  logic [31:0] memDataIn,
    output logic        validOut,
    output logic [31:0] pcOut,
    output logic [31:0] instOut,
    output logic        flushOut
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_q, flush_d;
    logic          push, pop;
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];

    always_comb begin
        pop        = advanceIn && (count_q != '0) && !redirectIn;
        push       = (state_q == WAIT) && memAckIn && !redirectIn;
        state_d    = state_q;
        addr_d     = addr_q;
        flush_d    = redirectIn;
        fetch_pc_d = redirectIn ? (redirectPcIn & ~32'd3) : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        case (state_q)
            // Issue only when a slot is guaranteed free by the time the ack can land
            IDLE: if (!redirectIn && ((count_q < CW'(FIFO_DEPTH)) || pop)) begin
                state_d = WAIT;
                addr_d  = fetch_pc_q;
            end
            WAIT:    state_d = memAckIn ? IDLE : redirectIn ? DROP : WAIT;
            DROP:    state_d = memAckIn ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
        count_d  = redirectIn ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d = redirectIn ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = redirectIn ? '0 : wr_ptr_q + AW'(push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= addr_q;
            fifo_inst_q[wr_ptr_q] <= memDataIn;
        end
    end

    assign memReqOut  = (state_q != IDLE);
    assign memAddrOut = addr_q;
    assign validOut   = (count_q != '0);
    assign pcOut      = validOut ? fifo_pc_q[rd_ptr_q] : 32'd0;
    assign instOut    = validOut ? fifo_inst_q[rd_ptr_q] : NOP_INST;
    assign flushOut   = flush_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: vector table, hand-written corner sequences and a randomized run
// against a queue-based reference model of the fetch unit.
module tb_inst_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        advanceIn, redirectIn, memAckIn;
    logic [31:0] redirectPcIn, memDataIn;
    logic        memReqOut, validOut, flushOut;
    logic [31:0] memAddrOut, pcOut, instOut;

    int vec_cnt = 0;
    int err_cnt = 0;

    inst_fetch_unit dut (
        .clk(clk), .reset(reset), .advanceIn(advanceIn), .redirectIn(redirectIn),
        .redirectPcIn(redirectPcIn), .memReqOut(memReqOut), .memAddrOut(memAddrOut),
        .memAckIn(memAckIn), .memDataIn(memDataIn), .validOut(validOut), .pcOut(pcOut),
        .instOut(instOut), .flushOut(flushOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a, r; logic [31:0] rp; logic k; logic [31:0] d;
        logic v; logic [31:0] pc, inst; logic req; logic [31:0] addr; logic fl;
    } vec_t;

    vec_t tbl[18];

    // Reference model: queue of buffered entries plus the one outstanding request
    logic [31:0] mq_pc[$], mq_in[$];
    logic [31:0] m_fetch, m_addr;
    logic        m_busy, m_stale, m_flush;

    function automatic vec_t mk(input logic a, r, input logic [31:0] rp, input logic k,
                                input logic [31:0] d, input logic v, input logic [31:0] pc, inst,
                                input logic req, input logic [31:0] addr, input logic fl);
        vec_t x;
        x.a = a; x.r = r; x.rp = rp; x.k = k; x.d = d;
        x.v = v; x.pc = pc; x.inst = inst; x.req = req; x.addr = addr; x.fl = fl;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check_out(input string t, input logic v, input logic [31:0] pc, inst,
                             input logic req, input logic [31:0] addr, input logic fl);
        chk({t, ".valid"}, 32'(validOut), 32'(v));
        chk({t, ".pc"}, pcOut, pc);
        chk({t, ".inst"}, instOut, inst);
        chk({t, ".req"}, 32'(memReqOut), 32'(req));
        chk({t, ".addr"}, memAddrOut, addr);
        chk({t, ".flush"}, 32'(flushOut), 32'(fl));
    endtask

    task automatic drive(input logic a, r, input logic [31:0] rp, input logic k, input logic [31:0] d);
        advanceIn = a; redirectIn = r; redirectPcIn = rp; memAckIn = k; memDataIn = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mq_pc.delete(); mq_in.delete();
        m_fetch = 32'd0; m_addr = 32'd0; m_busy = 0; m_stale = 0; m_flush = 0;
    endtask

    // Advances the model by one clock using the inputs currently driven
    task automatic model_step();
        logic pop;
        pop = advanceIn && (mq_pc.size() != 0) && !redirectIn;
        m_flush = redirectIn;
        if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_in.pop_front());
        end
        if (m_busy) begin
            if (memAckIn) begin
                m_busy = 0;
                if (!redirectIn && !m_stale) begin
                    mq_pc.push_back(m_addr);
                    mq_in.push_back(memDataIn);
                    m_fetch = m_fetch + 32'd4;
                end
            end else if (redirectIn) m_stale = 1;
        end else if (!redirectIn && mq_pc.size() < DEPTH) begin
            m_busy = 1; m_stale = 0; m_addr = m_fetch;
        end
        if (redirectIn) begin
            mq_pc.delete(); mq_in.delete();
            m_fetch = redirectPcIn & ~32'd3;
        end
    endtask

    initial begin
        int pushes;
        logic [31:0] rp;
        //              a  r  rpc        k  data            v  pc         inst           req addr        fl
        tbl[0]  = mk(1, 0, 0,         0, 0,            0, 0,         NOP,           1, 0,          0);
        tbl[1]  = mk(1, 0, 0,         1, 32'hA000_0000, 1, 0,         32'hA000_0000, 0, 0,          0);
        tbl[2]  = mk(1, 0, 0,         0, 0,            0, 0,         NOP,           1, 4,          0);
        tbl[3]  = mk(1, 0, 0,         1, 32'hA000_0001, 1, 4,         32'hA000_0001, 0, 4,          0);
        tbl[4]  = mk(1, 0, 0,         0, 0,            0, 0,         NOP,           1, 8,          0);
        tbl[5]  = mk(1, 0, 0,         1, 32'hA000_0002, 1, 8,         32'hA000_0002, 0, 8,          0);
        tbl[6]  = mk(0, 0, 0,         0, 0,            1, 8,         32'hA000_0002, 1, 12,         0);
        tbl[7]  = mk(0, 0, 0,         1, 32'hA000_0003, 1, 8,         32'hA000_0002, 0, 12,         0);
        tbl[8]  = mk(0, 0, 0,         0, 0,            1, 8,         32'hA000_0002, 1, 16,         0);
        tbl[9]  = mk(0, 0, 0,         1, 32'hA000_0004, 1, 8,         32'hA000_0002, 0, 16,         0);
        tbl[10] = mk(0, 0, 0,         0, 0,            1, 8,         32'hA000_0002, 1, 20,         0);
        tbl[11] = mk(0, 0, 0,         1, 32'hA000_0005, 1, 8,         32'hA000_0002, 0, 20,         0);
        tbl[12] = mk(0, 0, 0,         0, 0,            1, 8,         32'hA000_0002, 0, 20,         0);
        tbl[13] = mk(1, 0, 0,         0, 0,            1, 12,        32'hA000_0003, 1, 24,         0);
        tbl[14] = mk(1, 0, 0,         1, 32'hA000_0006, 1, 16,        32'hA000_0004, 0, 24,         0);
        tbl[15] = mk(1, 1, 32'h203,   0, 0,            0, 0,         NOP,           0, 24,         1);
        tbl[16] = mk(0, 0, 0,         0, 0,            0, 0,         NOP,           1, 32'h200,    0);
        tbl[17] = mk(0, 0, 0,         1, 32'hA000_0007, 1, 32'h200,   32'hA000_0007, 0, 32'h200,    0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #3 check_out("reset", 0, 0, NOP, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].a, tbl[i].r, tbl[i].rp, tbl[i].k, tbl[i].d);
            step();
            check_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].req, tbl[i].addr, tbl[i].fl);
        end

        // Consumer stalled: exactly DEPTH words fetched, then requests stop
        do_reset();
        pushes = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, memReqOut, 32'h5000_0000 + c);
            if (memReqOut) pushes++;
            step();
        end
        chk("full.pushes", pushes, DEPTH);
        chk("full.req", 32'(memReqOut), 0);
        drive(1, 0, 0, 0, 0);
        step();
        check_out("full.resume", 1, 4, 32'h5000_0003, 1, 32'h10, 0);

        // Redirect while waiting; stale ack arrives three cycles later
        do_reset();
        step();
        drive(0, 1, 32'h103, 0, 0);
        step();
        check_out("drop.redir", 0, 0, NOP, 1, 0, 1);
        drive(0, 0, 0, 0, 0);
        step();
        check_out("drop.hold1", 0, 0, NOP, 1, 0, 0);
        step();
        check_out("drop.hold2", 0, 0, NOP, 1, 0, 0);
        drive(0, 0, 0, 1, 32'hDEAD_DEAD);
        step();
        check_out("drop.ack", 0, 0, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        step();
        check_out("drop.reissue", 0, 0, NOP, 1, 32'h100, 0);
        drive(0, 0, 0, 1, 32'hBEEF_0001);
        step();
        check_out("drop.data", 1, 32'h100, 32'hBEEF_0001, 0, 32'h100, 0);

        // Redirect coincident with the ack
        do_reset();
        step();
        drive(0, 1, 32'h40, 1, 32'h1111_1111);
        step();
        check_out("same.redir", 0, 0, NOP, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        step();
        check_out("same.next", 0, 0, NOP, 1, 32'h40, 0);

        // Asynchronous reset mid-WAIT with two entries buffered
        do_reset();
        for (int c = 0; c < 2; c++) begin
            step();
            drive(0, 0, 0, 1, 32'h7000_0000 + c);
            step();
            drive(0, 0, 0, 0, 0);
        end
        step();
        check_out("areset.pre", 1, 0, 32'h7000_0000, 1, 8, 0);
        reset = 1'b1;
        #1 check_out("areset.now", 0, 0, NOP, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        check_out("areset.restart", 0, 0, NOP, 1, 0, 0);

        // Address wrap at the top of memory
        do_reset();
        drive(0, 1, 32'hFFFF_FFFF, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("wrap.addr0", memAddrOut, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 32'h2222_2222);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        check_out("wrap.next", 1, 32'hFFFF_FFFC, 32'h2222_2222, 1, 0, 0);

        // Randomized run against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rp = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | $urandom) : $urandom;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0, rp,
                  memReqOut && ($urandom_range(0, 2) != 0), $urandom);
            model_step();
            step();
            check_out("rand", mq_pc.size() != 0, (mq_pc.size() != 0) ? mq_pc[0] : 32'd0,
                      (mq_in.size() != 0) ? mq_in[0] : NOP, m_busy, m_addr, m_flush);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
